// File: rtl/ese461_pkg.sv
// ese461_pkg: Q8.8 datapath constants and the window feeder FSM states.
package ese461_pkg;
   localparam int Q_W = 16;
   localparam int FRAC_BITS = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;
endpackage

// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if: valid/ready result port carrying the finished dot product.
interface conv_window_feeder_if;
   logic [ese461_pkg::Q_W-1:0] out_data;
   logic out_valid;
   logic out_ready;
   modport master (output out_data, out_valid, input out_ready);
   modport slave (input out_data, out_valid, output out_ready);
endinterface

// File: rtl/conv_window_feeder_addr_gen.sv
// window_addr_gen: walks the window row/column, producing pixel and weight addresses.
module window_addr_gen #(
   parameter int AW = 10,
   parameter int KDIM_W = 3,
   parameter int IMG_W = 28
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [KDIM_W-1:0] kw,
   input  logic [KDIM_W-1:0] kh,
   input  logic [AW-1:0]     pix_base,
   input  logic [AW-1:0]     wgt_base,
   output logic [AW-1:0]     pix_addr,
   output logic [AW-1:0]     wgt_addr,
   output logic              first_tap,
   output logic              last_tap
);
   logic [KDIM_W-1:0] kw_q, kh_q, col, row;
   logic [AW-1:0] row_start;
   logic col_end;
   assign col_end = col == kw_q - KDIM_W'(1);
   assign first_tap = col == '0 && row == '0;
   assign last_tap = col_end && row == kh_q - KDIM_W'(1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         kw_q <= '0;
         kh_q <= '0;
         col <= '0;
         row <= '0;
         row_start <= '0;
         pix_addr <= '0;
         wgt_addr <= '0;
      end else if (load) begin
         kw_q <= kw;
         kh_q <= kh;
         col <= '0;
         row <= '0;
         row_start <= pix_base;
         pix_addr <= pix_base;
         wgt_addr <= wgt_base;
      end else if (advance) begin
         wgt_addr <= wgt_addr + AW'(1);
         col <= col_end ? '0 : col + KDIM_W'(1);
         row <= col_end ? row + KDIM_W'(1) : row;
         row_start <= col_end ? row_start + AW'(IMG_W) : row_start;
         pix_addr <= col_end ? row_start + AW'(IMG_W) : pix_addr + AW'(1);
      end
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: sequences a KH x KW window into the Q8.8 MAC and returns the dot product.
module conv_window_feeder import ese461_pkg::*; #(
   parameter int AW = 10,
   parameter int KDIM_W = 3,
   parameter int IMG_W = 28
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [KDIM_W-1:0]    kw,
   input  logic [KDIM_W-1:0]    kh,
   input  logic [AW-1:0]        pix_base,
   input  logic [AW-1:0]        wgt_base,
   input  logic [Q_W-1:0]       bias,
   output logic                 pix_rd,
   output logic [AW-1:0]        pix_addr,
   input  logic [Q_W-1:0]       pix_data,
   output logic                 wgt_rd,
   output logic [AW-1:0]        wgt_addr,
   input  logic [Q_W-1:0]       wgt_data,
   output logic [Q_W-1:0]       mac_pixel,
   output logic [Q_W-1:0]       mac_weight,
   output logic [Q_W-1:0]       mac_accum,
   input  logic [Q_W-1:0]       mac_result,
   conv_window_feeder_if.master out_port,
   output logic                 busy
);
   state_t state, state_nx;
   logic load, zero_win, tap_v, first_v, drain_cnt, first_tap, last_tap;
   logic [Q_W-1:0] bias_q, out_q;
   assign load = state == IDLE && start;
   assign zero_win = kw == '0 || kh == '0;
   assign pix_rd = state == ISSUE;
   assign wgt_rd = pix_rd;
   assign busy = state != IDLE;
   assign mac_pixel = tap_v ? pix_data : '0;
   assign mac_weight = tap_v ? wgt_data : '0;
   assign mac_accum = tap_v ? (first_v ? bias_q : mac_result) : '0;
   assign out_port.out_data = out_q;
   assign out_port.out_valid = state == OUT;
   window_addr_gen #(.AW(AW), .KDIM_W(KDIM_W), .IMG_W(IMG_W)) u_addr (
      .clk(clk), .reset(reset), .load(load), .advance(pix_rd),
      .kw(kw), .kh(kh), .pix_base(pix_base), .wgt_base(wgt_base),
      .pix_addr(pix_addr), .wgt_addr(wgt_addr),
      .first_tap(first_tap), .last_tap(last_tap)
   );
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = zero_win ? OUT : ISSUE;
         ISSUE:   if (last_tap) state_nx = DRAIN;
         DRAIN:   if (drain_cnt) state_nx = OUT;
         OUT:     if (out_port.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // drain_cnt marks the second DRAIN cycle, when the last tap's MAC result is registered
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         tap_v <= 1'b0;
         first_v <= 1'b0;
         drain_cnt <= 1'b0;
         bias_q <= '0;
         out_q <= '0;
      end else begin
         state <= state_nx;
         tap_v <= pix_rd;
         first_v <= pix_rd && first_tap;
         drain_cnt <= state == DRAIN && !drain_cnt;
         if (load) bias_q <= bias;
         if (load && zero_win) out_q <= bias;
         else if (state == DRAIN && drain_cnt) out_q <= mac_result;
      end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: SRAM and MAC models around the feeder, checked against a window-sum model.
module tb_conv_window_feeder;
   logic clk, reset, start, pix_rd, wgt_rd, busy;
   logic [2:0] kw, kh;
   logic [9:0] pix_base, wgt_base, pix_addr, wgt_addr;
   logic [15:0] bias, pix_data, wgt_data, mac_pixel, mac_weight, mac_accum, mac_result;
   logic [15:0] pix_mem [1024];
   logic [15:0] wgt_mem [1024];
   int pq[$], wq[$];
   int n_chk, n_fail;
   conv_window_feeder_if oif();
   conv_window_feeder dut (
      .clk(clk), .reset(reset), .start(start), .kw(kw), .kh(kh),
      .pix_base(pix_base), .wgt_base(wgt_base), .bias(bias),
      .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
      .wgt_rd(wgt_rd), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
      .mac_pixel(mac_pixel), .mac_weight(mac_weight), .mac_accum(mac_accum),
      .mac_result(mac_result), .out_port(oif), .busy(busy)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   function automatic logic [15:0] prod16(input logic [15:0] p, input logic [15:0] w);
      logic signed [31:0] pr;
      pr = $signed(p) * $signed(w);
      return pr[ese461_pkg::FRAC_BITS +: 16];
   endfunction
   always @(posedge clk) begin
      if (pix_rd) pix_data <= pix_mem[pix_addr];
      if (wgt_rd) wgt_data <= wgt_mem[wgt_addr];
      mac_result <= mac_accum + prod16(mac_pixel, mac_weight);
   end
   always @(negedge clk)
      if (pix_rd || wgt_rd) begin
         pq.push_back(int'(pix_addr));
         wq.push_back(int'(wgt_addr));
      end
   function automatic logic [87:0] all_out();
      return {pix_rd, wgt_rd, pix_addr, wgt_addr, mac_pixel, mac_weight, mac_accum,
              oif.out_data, oif.out_valid, busy};
   endfunction
   function automatic logic [15:0] model_sum(input int kwv, khv, pb, wb, input logic [15:0] b);
      logic [15:0] acc;
      acc = b;
      for (int r = 0; r < khv; r++)
         for (int c = 0; c < kwv; c++)
            acc = acc + prod16(pix_mem[(pb + r * 28 + c) % 1024], wgt_mem[(wb + r * kwv + c) % 1024]);
      return acc;
   endfunction
   task automatic run_window(input string name, input int kwv, khv, pb, wb,
                             input logic [15:0] b, output logic [15:0] got);
      int ep[$], ew[$];
      int cyc, lat, bad;
      logic [15:0] exp_d;
      exp_d = model_sum(kwv, khv, pb, wb, b);
      for (int r = 0; r < khv; r++)
         for (int c = 0; c < kwv; c++) begin
            ep.push_back((pb + r * 28 + c) % 1024);
            ew.push_back((wb + r * kwv + c) % 1024);
         end
      lat = (kwv == 0 || khv == 0) ? 1 : kwv * khv + 3;
      @(negedge clk);
      pq.delete();
      wq.delete();
      kw = 3'(kwv); kh = 3'(khv); pix_base = 10'(pb); wgt_base = 10'(wb); bias = b;
      oif.out_ready = 1; start = 1;
      @(negedge clk);
      start = 0;
      cyc = 1;
      while (!oif.out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      n_chk++;
      if (cyc !== lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
      end
      n_chk++;
      if (oif.out_data !== exp_d) begin
         n_fail++;
         $display("FAIL %s out_data: got %h expected %h", name, oif.out_data, exp_d);
      end
      got = oif.out_data;
      bad = 0;
      if (pq.size() != ep.size()) bad++;
      else foreach (ep[i]) if (pq[i] != ep[i] || wq[i] != ew[i]) bad++;
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s addresses: got %0d reads %0d bad expected %0d reads", name, pq.size(), bad, ep.size());
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || oif.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_after_accept: got busy=%b valid=%b expected 0 0", name, busy, oif.out_valid);
      end
   endtask
   task automatic test_reset();
      reset = 0; start = 0; kw = 0; kh = 0; pix_base = 0; wgt_base = 0; bias = 0;
      oif.out_ready = 1;
      #1;
      n_chk++;
      if (all_out() !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", all_out());
      end
      repeat (2) @(negedge clk);
      reset = 1;
   endtask
   task automatic test_1x1();
      logic [15:0] got;
      pix_mem[5] = 16'h0200;
      wgt_mem[7] = 16'h0300;
      run_window("1x1", 1, 1, 5, 7, 16'h0100, got);
      n_chk++;
      if (got !== 16'h0700) begin
         n_fail++;
         $display("FAIL 1x1_const: got %h expected 0700", got);
      end
   endtask
   task automatic test_3x3();
      logic [15:0] got;
      int exp9[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
      int bad;
      foreach (pix_mem[i]) begin
         pix_mem[i] = 16'h0100;
         wgt_mem[i] = 16'h0080;
      end
      run_window("3x3", 3, 3, 0, 0, 16'h0000, got);
      n_chk++;
      if (got !== 16'h0480) begin
         n_fail++;
         $display("FAIL 3x3_const: got %h expected 0480", got);
      end
      bad = 0;
      if (pq.size() != 9) bad++;
      else foreach (exp9[i]) if (pq[i] != exp9[i]) bad++;
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL 3x3_pix_addr: got %0d reads %0d bad expected 9 reads", pq.size(), bad);
      end
   endtask
   task automatic test_zero();
      logic [15:0] got;
      run_window("kw0", 0, 3, 10, 10, 16'h1234, got);
      n_chk++;
      if (got !== 16'h1234 || pq.size() != 0) begin
         n_fail++;
         $display("FAIL kw0_bias: got %h reads %0d expected 1234 reads 0", got, pq.size());
      end
      run_window("kh0", 4, 0, 10, 10, 16'hBEEF, got);
   endtask
   task automatic test_overflow();
      logic [15:0] got;
      pix_mem[1023] = 16'h7F00;
      pix_mem[0] = 16'h7F00;
      wgt_mem[100] = 16'h0200;
      wgt_mem[101] = 16'h0200;
      run_window("overflow", 2, 1, 1023, 100, 16'h0000, got);
      n_chk++;
      if (got !== 16'hFC00 || pq.size() != 2 || pq[0] != 1023 || pq[1] != 0) begin
         n_fail++;
         $display("FAIL overflow_wrap: got %h reads %0d expected FC00 addresses 1023,0", got, pq.size());
      end
   endtask
   task automatic test_backpressure();
      logic [15:0] exp_d;
      int cyc;
      exp_d = model_sum(2, 2, 40, 10, 16'h0011);
      @(negedge clk);
      kw = 2; kh = 2; pix_base = 40; wgt_base = 10; bias = 16'h0011;
      oif.out_ready = 0; start = 1;
      @(negedge clk);
      start = 0;
      cyc = 1;
      while (!oif.out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (oif.out_valid !== 1'b1 || oif.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got valid=%b data=%h expected 1 %h", i, oif.out_valid, oif.out_data, exp_d);
         end
         start = (i == 1);
         if (i == 1) begin
            kw = 1; kh = 1; bias = 16'h5555;
         end
         @(negedge clk);
      end
      start = 0;
      n_chk++;
      if (oif.out_valid !== 1'b1 || oif.out_data !== exp_d) begin
         n_fail++;
         $display("FAIL bp_after_start: got valid=%b data=%h expected 1 %h", oif.out_valid, oif.out_data, exp_d);
      end
      oif.out_ready = 1; start = 1;
      @(negedge clk);
      start = 0;
      n_chk++;
      if (busy !== 1'b0 || oif.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_start_on_accept: got busy=%b valid=%b expected 0 0", busy, oif.out_valid);
      end
   endtask
   task automatic test_reset_mid();
      logic [15:0] got;
      bit seen;
      @(negedge clk);
      kw = 3; kh = 3; pix_base = 0; wgt_base = 0; bias = 16'h0042; start = 1;
      @(negedge clk);
      start = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      #1;
      n_chk++;
      if (all_out() !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %h expected 0", all_out());
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (oif.out_valid) seen = 1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_no_valid: got %b expected 0", seen);
      end
      reset = 1;
      run_window("after_reset", 3, 3, 200, 300, 16'h0042, got);
   endtask
   task automatic test_random();
      logic [15:0] got;
      foreach (pix_mem[i]) begin
         pix_mem[i] = 16'($urandom);
         wgt_mem[i] = 16'($urandom);
      end
      for (int i = 0; i < 10; i++)
         run_window($sformatf("rand%0d", i), int'($urandom_range(0, 7)), int'($urandom_range(1, 7)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 16'($urandom), got);
   endtask
   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_1x1();
      test_3x3();
      test_zero();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
